// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system PIO-style Avalon-MM slaves.
package soc_system_pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_sync_edge.sv
// Two-flop synchronizer, previous-value register, warm-up counter and
// edge vector generation for the status input port.
module soc_system_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH     = 11,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_prev;
  logic [1:0]       r_warm;
  logic [WIDTH-1:0] w_raw;
  logic             w_en;

  // Synchronizer chain plus a saturating warm-up counter that holds off
  // detection until s1/s2/prev all carry real input history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_warm <= 2'd0;
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  assign w_en = (r_warm == 2'd3);

  // Select the edge flavour; gated off during warm-up so a level held high
  // through reset never looks like an edge.
  always_comb begin
    w_raw = r_s2 & ~r_prev;
    if (EDGE_TYPE == EDGE_FALLING) begin
      w_raw = ~r_s2 & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      w_raw = r_s2 ^ r_prev;
    end
    o_edge = w_en ? w_raw : '0;
  end

  assign o_data = r_s2;

endmodule

// File: rtl/soc_system_status_in.sv
// Avalon-MM status input port: synchronized data, maskable per-bit edge
// capture with write-1-to-clear, registered read path and level irq.
module soc_system_status_in
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH      = 11,
  parameter int               EDGE_TYPE  = 0,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  output logic             readdatavalid,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [BUS_W-1:0] w_rmux;
  logic             w_wr;
  logic             w_rd;
  logic             w_unused_wd;

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic             r_irq;
  logic [BUS_W-1:0] r_rdata;
  logic             r_rvalid;

  soc_system_sync_edge #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .i_in   (in_port),
    .o_data (w_data),
    .o_edge (w_edge)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_rd        = chipselect & ~read_n;
  assign w_unused_wd = ^writedata;

  // Decode the W1C vector and the zero-extended read mux from current state,
  // so reads always observe pre-update values.
  always_comb begin
    w_clr  = '0;
    w_rmux = '0;
    if (w_wr && (address == ADDR_EDGE)) begin
      w_clr = writedata[WIDTH-1:0];
    end
    case (address)
      ADDR_DATA: w_rmux[WIDTH-1:0] = w_data;
      ADDR_MASK: w_rmux[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rmux[WIDTH-1:0] = r_ecap;
      default:   w_rmux = '0;
    endcase
  end

  // Register file, capture (edge beats same-cycle clear), irq and read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask   <= RESET_MASK;
      r_ecap   <= '0;
      r_irq    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      r_ecap   <= (r_ecap & ~w_clr) | w_edge;
      r_irq    <= |(r_ecap & r_mask);
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rmux;
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;
  assign irq           = r_irq;

endmodule

// File: tb/tb_soc_system_status_in.sv
// Directed bench for soc_system_status_in: rising, falling and any-edge
// instances share one bus; each has its own in_port.
module tb_soc_system_status_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [10:0] ip0 = 11'd0;
  logic [10:0] ip1 = 11'd0;
  logic [10:0] ip2 = 11'd0;
  logic [31:0] rd0, rd1, rd2;
  logic        rv0, rv1, rv2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_status_in #(.WIDTH(11), .EDGE_TYPE(0), .RESET_MASK(11'h000)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .readdatavalid(rv0), .irq(irq0), .in_port(ip0));

  soc_system_status_in #(.WIDTH(11), .EDGE_TYPE(1), .RESET_MASK(11'h0F0)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .readdatavalid(rv1), .irq(irq1), .in_port(ip1));

  soc_system_status_in #(.WIDTH(11), .EDGE_TYPE(2), .RESET_MASK(11'h000)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd2), .readdatavalid(rv2), .irq(irq2), .in_port(ip2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    ip0 = 11'h7FF; ip1 = 11'h7FF; ip2 = 11'h7FF;
    do_reset();
    checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h exp %h", rd0, 32'd0); end
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", rv0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq0); end
    repeat (10) tick();
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL warmup_irq: got %b exp 0", irq2); end
    bus_read(2'd3);
    checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL warmup_ecap0: got %h exp 0", rd0); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL warmup_ecap2: got %h exp 0", rd2); end
    bus_read(2'd0);
    checks++; if (rd0 !== 32'h000007FF) begin errors++; $display("FAIL reset_data_read: got %h exp %h", rd0, 32'h7FF); end
    checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL read_valid: got %b exp 1", rv0); end
    tick();
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL read_valid_pulse: got %b exp 0", rv0); end
    bus_read(2'd2);
    checks++; if (rd1 !== 32'h0F0) begin errors++; $display("FAIL reset_mask1: got %h exp %h", rd1, 32'h0F0); end
    checks++; if (rd0 !== 32'h000) begin errors++; $display("FAIL reset_mask0: got %h exp 0", rd0); end
    ip0 = 11'h000; ip2 = 11'h000;
    repeat (4) tick();
    bus_write(2'd3, 32'h7FF);
    tick();
  endtask

  task automatic test_rising_irq;
    bus_write(2'd2, 32'h004);
    ip0 = 11'h004;
    repeat (3) tick();
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early: got %b exp 0", irq0); end
    tick();
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_latency4: got %b exp 1", irq0); end
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h004) begin errors++; $display("FAIL rise_ecap: got %h exp %h", rd0, 32'h004); end
    bus_write(2'd3, 32'h004);
    tick();
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b exp 0", irq0); end
  endtask

  task automatic test_edge_vs_w1c;
    ip0 = 11'h024;
    tick();
    tick();
    bus_write(2'd3, 32'h020);
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h020) begin errors++; $display("FAIL edge_wins_w1c: got %h exp %h", rd0, 32'h020); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL masked_bit5_irq: got %b exp 0", irq0); end
    bus_write(2'd3, 32'h020);
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h000) begin errors++; $display("FAIL read_after_w1c: got %h exp 0", rd0); end
  endtask

  task automatic test_mask_later;
    bus_write(2'd2, 32'h000);
    ip0 = 11'h025;
    repeat (4) tick();
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h001) begin errors++; $display("FAIL mask0_ecap: got %h exp %h", rd0, 32'h001); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL mask0_irq: got %b exp 0", irq0); end
    bus_write(2'd2, 32'h001);
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL unmask_irq_same: got %b exp 0", irq0); end
    tick();
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b exp 1", irq0); end
    bus_write(2'd3, 32'h001);
    tick();
  endtask

  task automatic test_falling;
    ip1 = 11'h77F;
    repeat (3) tick();
    bus_read(2'd3);
    checks++; if (rd1 !== 32'h080) begin errors++; $display("FAIL fall_ecap: got %h exp %h", rd1, 32'h080); end
    checks++; if (rd0 !== 32'h000) begin errors++; $display("FAIL rise_idle_ecap: got %h exp 0", rd0); end
    bus_write(2'd3, 32'h7FF);
  endtask

  task automatic test_any_edge;
    ip2 = 11'h400;
    repeat (3) tick();
    bus_read(2'd3);
    checks++; if (rd2 !== 32'h400) begin errors++; $display("FAIL any_rise: got %h exp %h", rd2, 32'h400); end
    bus_write(2'd3, 32'h400);
    bus_read(2'd3);
    checks++; if (rd2 !== 32'h000) begin errors++; $display("FAIL any_clear: got %h exp 0", rd2); end
    ip2 = 11'h000;
    repeat (3) tick();
    bus_read(2'd3);
    checks++; if (rd2 !== 32'h400) begin errors++; $display("FAIL any_fall: got %h exp %h", rd2, 32'h400); end
    bus_read(2'd1);
    checks++; if (rd2 !== 32'h000) begin errors++; $display("FAIL addr1_read: got %h exp 0", rd2); end
    checks++; if (rv2 !== 1'b1) begin errors++; $display("FAIL addr1_valid: got %b exp 1", rv2); end
    bus_write(2'd0, 32'h3FF);
    bus_read(2'd3);
    checks++; if (rd2 !== 32'h400) begin errors++; $display("FAIL addr0_write_ecap: got %h exp %h", rd2, 32'h400); end
    bus_read(2'd2);
    checks++; if (rd2 !== 32'h001) begin errors++; $display("FAIL addr0_write_mask: got %h exp %h", rd2, 32'h001); end
    bus_read(2'd0);
    checks++; if (rd2 !== 32'h000) begin errors++; $display("FAIL addr0_write_data: got %h exp 0", rd2); end
  endtask

  task automatic test_simul_rw;
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 2'd2; writedata = 32'h0AA;
    tick();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = 32'd0;
    checks++; if (rd0 !== 32'h001) begin errors++; $display("FAIL rw_pre_write: got %h exp %h", rd0, 32'h001); end
    checks++; if (rv0 !== 1'b1) begin errors++; $display("FAIL rw_valid: got %b exp 1", rv0); end
    bus_read(2'd2);
    checks++; if (rd0 !== 32'h0AA) begin errors++; $display("FAIL rw_post_write: got %h exp %h", rd0, 32'h0AA); end
  endtask

  task automatic test_back_to_back;
    chipselect = 1'b1; read_n = 1'b0; address = 2'd2;
    tick();
    checks++; if (rd0 !== 32'h0AA || rv0 !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b exp %h/1", rd0, rv0, 32'h0AA); end
    address = 2'd0;
    tick();
    checks++; if (rd0 !== 32'h025 || rv0 !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b exp %h/1", rd0, rv0, 32'h025); end
    chipselect = 1'b0; read_n = 1'b1;
    tick();
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b exp 0", rv0); end
  endtask

  task automatic test_reset_mid;
    ip0 = 11'h000;
    repeat (4) tick();
    bus_write(2'd3, 32'h7FF);
    ip0 = 11'h3FF;
    repeat (3) tick();
    bus_write(2'd2, 32'h7FF);
    tick();
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b exp 1", irq0); end
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h3FF) begin errors++; $display("FAIL pre_reset_ecap: got %h exp %h", rd0, 32'h3FF); end
    reset = 1'b1; chipselect = 1'b1; read_n = 1'b0; address = 2'd3;
    tick();
    reset = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL reset_read_valid: got %b exp 0", rv0); end
    checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL reset_read_data: got %h exp 0", rd0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b exp 0", irq0); end
    repeat (6) tick();
    bus_read(2'd3);
    checks++; if (rd0 !== 32'h000) begin errors++; $display("FAIL mid_reset_ecap: got %h exp 0", rd0); end
    bus_read(2'd2);
    checks++; if (rd0 !== 32'h000) begin errors++; $display("FAIL mid_reset_mask0: got %h exp 0", rd0); end
    checks++; if (rd1 !== 32'h0F0) begin errors++; $display("FAIL mid_reset_mask1: got %h exp %h", rd1, 32'h0F0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b exp 0", irq0); end
  endtask

  initial begin
    test_reset();
    test_rising_irq();
    test_edge_vs_w1c();
    test_mask_later();
    test_falling();
    test_any_edge();
    test_simul_rw();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
